// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/sequence stage ahead of the control decoder
module instr_sequencer #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [IW-1:0]   imem_data,
    input  logic            branch,
    input  logic            ldpc,
    input  logic [PC_W-1:0] pc_load_val,
    output logic [3:0]      opcode,
    output logic [3:0]      rx_sel,
    output logic [3:0]      ry_sel,
    output logic [PC_W-1:0] imm,
    output logic [1:0]      step,
    output logic            exec,
    output logic            done,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic [1:0]    last_step;

    assign opcode    = ir[IW-1:IW-4];
    assign rx_sel    = ir[IW-5:IW-8];
    assign ry_sel    = ir[IW-9:IW-12];
    assign imm       = ir[PC_W-1:0];

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign exec      = (state == S_EXEC);
    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Only the ALU ops need the extra two cycles; everything else is single-step.
    always_comb begin
        last_step = 2'd0;
        if (opcode == OP_ADD || opcode == OP_XOR) begin
            last_step = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run && !halted) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (step == last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (opcode == OP_HALT) begin
                    state_nxt = S_IDLE;
                end else if (run) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            step   <= 2'd0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir   <= imem_data;
                        pc   <= pc + PC_W'(1);
                        step <= 2'd0;
                    end
                end
                S_EXEC: begin
                    step <= (step == last_step) ? 2'd0 : step + 2'd1;
                    // ldpc wins over branch when the decoder raises both.
                    if (ldpc) begin
                        pc <= pc_load_val;
                    end else if (branch) begin
                        pc <= imm;
                    end
                end
                S_DONE: begin
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer fetch, sequencing and pc control
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        branch;
    logic        ldpc;
    logic [7:0]  pc_load_val;
    logic [3:0]  opcode;
    logic [3:0]  rx_sel;
    logic [3:0]  ry_sel;
    logic [7:0]  imm;
    logic [1:0]  step;
    logic        exec;
    logic        done;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;

    instr_sequencer #(.PC_W(8), .IW(16)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .branch(branch), .ldpc(ldpc), .pc_load_val(pc_load_val),
        .opcode(opcode), .rx_sel(rx_sel), .ry_sel(ry_sel), .imm(imm),
        .step(step), .exec(exec), .done(done), .busy(busy),
        .halted(halted), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          nsteps;
        logic [7:0]  steplog;
        logic [7:0]  pc_after;
    } exp_t;

    typedef struct {
        bit          fetch_ok;
        logic [7:0]  addr;
        int          req_hold;
        bit          fetch_clean;
        int          n_exec;
        logic [7:0]  step_log;
        int          done_at;
        logic [15:0] ir_seen;
        logic [7:0]  pc_done;
    } res_t;

    exp_t       sb[$];
    logic [7:0] mpc;
    int         vectors;
    int         errors;

    function automatic int model_steps(input logic [3:0] op);
        return (op == 4'h2 || op == 4'h3) ? 3 : 1;
    endfunction

    function automatic logic [7:0] model_steplog(input int n);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < n; k++) v[k*2 +: 2] = 2'(k);
        return v;
    endfunction

    function automatic logic [7:0] model_pc(input logic [7:0] a, input logic [15:0] d,
                                            input bit br, input bit ld, input logic [7:0] v);
        if (ld) return v;
        if (br) return d[7:0];
        return a + 8'd1;
    endfunction

    task automatic push_exp(input logic [15:0] d, input bit br, input bit ld, input logic [7:0] v);
        exp_t e;
        e.addr     = mpc;
        e.data     = d;
        e.nsteps   = model_steps(d[15:12]);
        e.steplog  = model_steplog(e.nsteps);
        e.pc_after = model_pc(mpc, d, br, ld, v);
        mpc        = e.pc_after;
        sb.push_back(e);
    endtask

    // Serve one fetch with waitc wait cycles, then watch EXEC until the done pulse.
    task automatic exec_instr(input logic [15:0] d, input int waitc, input bit br, input bit ld,
                              input logic [7:0] ldv, input bit br_in_fetch, input bit spur,
                              input bit drop_run, output res_t r);
        int t;
        r.fetch_ok = 1'b1; r.fetch_clean = 1'b1; r.req_hold = 0; r.n_exec = 0;
        r.step_log = '0; r.done_at = 0; r.ir_seen = '0; r.addr = '0; r.pc_done = '0;
        branch = br_in_fetch;
        t = 0;
        @(negedge clk);
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        r.fetch_ok = imem_req;
        r.addr     = imem_addr;
        if (imem_req) r.req_hold = 1;
        for (int i = 0; i < waitc; i++) begin
            @(negedge clk);
            if (imem_req) r.req_hold++;
            if (!imem_req || imem_addr !== r.addr || exec) r.fetch_clean = 1'b0;
        end
        imem_data  = d;
        imem_valid = 1'b1;
        @(posedge clk);
        #1;
        imem_valid  = spur;
        imem_data   = spur ? 16'hF000 : 16'h0000;
        branch      = br;
        ldpc        = ld;
        pc_load_val = ldv;
        if (drop_run) run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (exec) begin
                if (r.n_exec < 4) r.step_log[r.n_exec*2 +: 2] = step;
                r.n_exec++;
                r.ir_seen = {opcode, rx_sel, imm};
            end
            if (done) begin
                r.done_at = c;
                break;
            end
        end
        r.pc_done  = pc;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        branch     = 1'b0;
        ldpc       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({imem_req, exec, done, busy, halted, step} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000", {imem_req, exec, done, busy, halted, step});
        end
        vectors++;
        if ({pc, imem_addr, opcode, rx_sel, ry_sel, imm} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", {pc, imem_addr, opcode, rx_sel, ry_sel, imm});
        end
        mpc = 8'h00;
    endtask

    task automatic test_basic();
        logic [15:0] dat [2] = '{16'h0300, 16'h0000};
        bit          ld  [2] = '{1'b0, 1'b1};
        logic [7:0]  ldv [2] = '{8'h00, 8'h05};
        exp_t e;
        res_t r;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_exp(dat[i], 1'b0, ld[i], ldv[i]);
            exec_instr(dat[i], 0, 1'b0, ld[i], ldv[i], 1'b0, 1'b0, 1'b0, r);
            e = sb.pop_front();
            vectors++; if (!r.fetch_ok) begin errors++; $display("FAIL basic[%0d] fetch: got no imem_req want imem_req", i); end
            vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL basic[%0d] addr: got %h want %h", i, r.addr, e.addr); end
            vectors++; if (r.n_exec !== e.nsteps) begin errors++; $display("FAIL basic[%0d] exec_cycles: got %0d want %0d", i, r.n_exec, e.nsteps); end
            vectors++; if (r.step_log !== e.steplog) begin errors++; $display("FAIL basic[%0d] steps: got %h want %h", i, r.step_log, e.steplog); end
            vectors++; if (r.done_at !== e.nsteps + 1) begin errors++; $display("FAIL basic[%0d] done_at: got %0d want %0d", i, r.done_at, e.nsteps + 1); end
            vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL basic[%0d] ir: got %h want %h", i, r.ir_seen, e.data); end
            vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL basic[%0d] pc: got %h want %h", i, r.pc_done, e.pc_after); end
        end
    endtask

    task automatic test_add_run_drop();
        exp_t e;
        res_t r;
        push_exp(16'h2120, 1'b0, 1'b0, 8'h00);
        exec_instr(16'h2120, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, r);
        e = sb.pop_front();
        vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL add addr: got %h want %h", r.addr, e.addr); end
        vectors++; if (r.n_exec !== e.nsteps) begin errors++; $display("FAIL add exec_cycles: got %0d want %0d", r.n_exec, e.nsteps); end
        vectors++; if (r.step_log !== e.steplog) begin errors++; $display("FAIL add steps: got %h want %h", r.step_log, e.steplog); end
        vectors++; if (r.done_at !== e.nsteps + 1) begin errors++; $display("FAIL add done_at: got %0d want %0d", r.done_at, e.nsteps + 1); end
        vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL add ir: got %h want %h", r.ir_seen, e.data); end
        vectors++; if (ry_sel !== 4'h2) begin errors++; $display("FAIL add ry_sel: got %h want 2", ry_sel); end
        vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL add pc: got %h want %h", r.pc_done, e.pc_after); end
        @(negedge clk);
        vectors++;
        if ({done, busy, imem_req} !== 3'b000) begin
            errors++;
            $display("FAIL add run_drop_idle: got done/busy/req %b want 000", {done, busy, imem_req});
        end
        run = 1'b1;
    endtask

    task automatic test_branch();
        logic [15:0] dat [3] = '{16'h0000, 16'h5040, 16'h5033};
        bit          br  [3] = '{1'b0, 1'b1, 1'b1};
        bit          ld  [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0]  ldv [3] = '{8'h10, 8'h00, 8'h22};
        exp_t e;
        res_t r;
        for (int i = 0; i < 3; i++) begin
            push_exp(dat[i], br[i], ld[i], ldv[i]);
            exec_instr(dat[i], 0, br[i], ld[i], ldv[i], 1'b0, 1'b0, 1'b0, r);
            e = sb.pop_front();
            vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL branch[%0d] addr: got %h want %h", i, r.addr, e.addr); end
            vectors++; if (r.n_exec !== e.nsteps) begin errors++; $display("FAIL branch[%0d] exec_cycles: got %0d want %0d", i, r.n_exec, e.nsteps); end
            vectors++; if (r.done_at !== e.nsteps + 1) begin errors++; $display("FAIL branch[%0d] done_at: got %0d want %0d", i, r.done_at, e.nsteps + 1); end
            vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL branch[%0d] ir: got %h want %h", i, r.ir_seen, e.data); end
            vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL branch[%0d] pc: got %h want %h", i, r.pc_done, e.pc_after); end
        end
    endtask

    task automatic test_wait_spurious();
        exp_t e;
        res_t r;
        push_exp(16'h3456, 1'b0, 1'b1, 8'hFF);
        exec_instr(16'h3456, 4, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, r);
        e = sb.pop_front();
        vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL wait addr: got %h want %h", r.addr, e.addr); end
        vectors++; if (r.req_hold !== 5) begin errors++; $display("FAIL wait req_hold: got %0d want 5", r.req_hold); end
        vectors++; if (r.fetch_clean !== 1'b1) begin errors++; $display("FAIL wait fetch_stable: got %b want 1", r.fetch_clean); end
        vectors++; if (r.n_exec !== e.nsteps) begin errors++; $display("FAIL wait exec_cycles: got %0d want %0d", r.n_exec, e.nsteps); end
        vectors++; if (r.step_log !== e.steplog) begin errors++; $display("FAIL wait steps: got %h want %h", r.step_log, e.steplog); end
        vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL wait spurious_ir: got %h want %h", r.ir_seen, e.data); end
        vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL wait pc: got %h want %h", r.pc_done, e.pc_after); end
    endtask

    task automatic test_wrap_halt();
        logic [15:0] dat [2] = '{16'h7000, 16'hF000};
        exp_t e;
        res_t r;
        bit   saw_req;
        for (int i = 0; i < 2; i++) begin
            push_exp(dat[i], 1'b0, 1'b0, 8'h00);
            exec_instr(dat[i], 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, r);
            e = sb.pop_front();
            vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL wrap[%0d] addr: got %h want %h", i, r.addr, e.addr); end
            vectors++; if (r.done_at !== e.nsteps + 1) begin errors++; $display("FAIL wrap[%0d] done_at: got %0d want %0d", i, r.done_at, e.nsteps + 1); end
            vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL wrap[%0d] ir: got %h want %h", i, r.ir_seen, e.data); end
            vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL wrap[%0d] pc: got %h want %h", i, r.pc_done, e.pc_after); end
        end
        saw_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) saw_req = 1'b1;
        end
        vectors++; if (saw_req !== 1'b0) begin errors++; $display("FAIL halt no_fetch: got imem_req=1 want 0"); end
        vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt halted: got %b want 1", halted); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL halt busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_fetch();
        exp_t e;
        res_t r;
        int   t;
        run = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mpc = 8'h00;
        run = 1'b1;
        t = 0;
        @(negedge clk);
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rstfetch pre_req: got %b want 1", imem_req); end
        imem_data  = 16'h2FFF;
        imem_valid = 1'b1;
        reset      = 1'b1;
        run        = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, imem_req, exec, halted, step} !== 6'b0) begin
            errors++;
            $display("FAIL rstfetch ctrl: got %b want 000000", {busy, imem_req, exec, halted, step});
        end
        vectors++;
        if ({pc, opcode, rx_sel, imm} !== 24'h0) begin
            errors++;
            $display("FAIL rstfetch data: got %h want 000000", {pc, opcode, rx_sel, imm});
        end
        @(negedge clk);
        vectors++;
        if ({busy, opcode} !== 5'b0) begin
            errors++;
            $display("FAIL rstfetch valid_ignored: got %b want 00000", {busy, opcode});
        end
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        run = 1'b1;
        push_exp(16'h1450, 1'b0, 1'b0, 8'h00);
        exec_instr(16'h1450, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, r);
        e = sb.pop_front();
        vectors++; if (r.addr !== e.addr) begin errors++; $display("FAIL rstfetch addr: got %h want %h", r.addr, e.addr); end
        vectors++; if (r.ir_seen !== e.data) begin errors++; $display("FAIL rstfetch ir: got %h want %h", r.ir_seen, e.data); end
        vectors++; if (r.pc_done !== e.pc_after) begin errors++; $display("FAIL rstfetch pc: got %h want %h", r.pc_done, e.pc_after); end
        run = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        mpc         = 8'h00;
        reset       = 1'b1;
        run         = 1'b0;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        branch      = 1'b0;
        ldpc        = 1'b0;
        pc_load_val = 8'h00;
        test_reset();
        test_basic();
        test_add_run_drop();
        test_branch();
        test_wait_spurious();
        test_wrap_halt();
        test_reset_mid_fetch();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/sequence stage sitting directly upstream of the processor's control decoder. It fetches 16-bit instruction words from instruction memory over a req/valid handshake and holds them in an instruction register. It presents opcode, register fields and a step count to the decoder, and steps through the per-opcode execution timing. It owns the program counter and applies the decoder's branch and ldpc requests.

Parameters:
PC_W, 8, program counter / instruction address width
IW, 16, instruction word width; fields are opcode [15:12], rx [11:8], ry [7:4], imm [PC_W-1:0]

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; sampled in IDLE and DONE to start or continue execution
imem_req  out  1  fetch request; high throughout FETCH
imem_addr  out  PC_W  fetch address, equals pc while imem_req=1
imem_valid  in  1  memory has returned data this cycle
imem_data  in  IW  instruction word, valid when imem_valid=1
branch  in  1  from decoder: load pc from ir imm field
ldpc  in  1  from decoder: load pc from pc_load_val
pc_load_val  in  PC_W  pc value for ldpc
opcode  out  4  ir[15:12]
rx_sel  out  4  ir[11:8]
ry_sel  out  4  ir[7:4]
imm  out  PC_W  ir[PC_W-1:0]
step  out  2  current execution step, 0-based
exec  out  1  high in EXEC; decoder outputs are only meaningful when high
done  out  1  one-cycle pulse after the last exec step
busy  out  1  high in any state other than IDLE
halted  out  1  sticky; set after a HALT instruction completes
pc  out  PC_W  current program counter

Behaviour:
- States: IDLE, FETCH, EXEC, DONE. State is registered. imem_req, exec, done and busy decode from the state.
- Reset values: state IDLE, pc 0, ir 0, step 0, halted 0. All outputs are therefore 0.
- Reset applies from any state, including mid-FETCH. A pending imem_valid is ignored on the reset edge and afterwards.
- IDLE: if run=1 and halted=0, go to FETCH. Otherwise stay.
- FETCH: imem_req=1 and imem_addr=pc. Wait without limit for imem_valid.
  - On imem_valid: ir <= imem_data, pc <= pc+1 (mod 2^PC_W; 0xFF wraps to 0x00), step <= 0, go to EXEC.
  - imem_valid in any other state is ignored.
- Step count N per opcode:
  - 0000 load: 1; 0001 mov: 1; 0101 branch: 1.
  - 0010 add: 3; 0011 xor: 3.
  - 1111 halt: 1.
  - All other opcodes: 1 (NOP).
- EXEC: exec=1. step increments each cycle. When step == N-1, go to DONE and reset step to 0.
- pc updates during EXEC, sampled every EXEC cycle:
  - ldpc=1: pc <= pc_load_val.
  - else branch=1: pc <= imm.
  - ldpc has priority when both are high.
  - branch/ldpc outside EXEC are ignored.
- DONE: done=1 for exactly one cycle.
  - If the opcode was 1111: halted <= 1, go to IDLE.
  - Else if run=1: go to FETCH.
  - Else: go to IDLE.
- run deasserted mid-instruction: the current instruction completes through DONE, then the block returns to IDLE. No instruction is aborted.
- halted stays set until reset. run is ignored while halted=1.
- Latency with zero-wait memory (imem_valid in the first FETCH cycle): 1 fetch + N exec + 1 done cycles. A 1-step instruction takes 3 cycles; add/xor takes 5 cycles.
- ir, and therefore opcode/rx_sel/ry_sel/imm, holds stable from the FETCH capture until the next capture.

Test Plan:
- Reset then run=1, memory returns 0x0300 with zero wait. Required: imem_addr=0x00; opcode=0000, rx_sel=3; exec high 1 cycle with step=0; done pulse; pc=0x01; next fetch at 0x01.
- add 0x2120 fetched at pc 0x05. Required: exec high 3 cycles with step 0,1,2; done on the 4th cycle after capture; pc=0x06.
- Branch 0x5040 at pc 0x10, with decoder branch=1 in EXEC. Required: pc=0x40 after EXEC; next imem_addr=0x40. With ldpc=1 and pc_load_val=0x22 asserted simultaneously, next imem_addr=0x22.
- Memory wait of 4 cycles. Required: imem_req held high and imem_addr stable for 5 cycles; capture only on the imem_valid cycle. A spurious imem_valid during EXEC does not change ir.
- pc=0xFF fetch. Required: pc wraps to 0x00. HALT 0xF000 with run held high. Required: done pulse, IDLE, halted=1, no further imem_req.
- Assert reset during FETCH while imem_valid=1 in the same cycle. Required: next cycle state IDLE, pc=0, ir=0, busy=0; run=1 afterwards restarts a fetch from 0x00.
